filtro_botao: RTL and testbench

FILTRO_BOTAO -- requirements
Module: filtro_botao

---
 rtl/filtro_pkg.sv | 12 +
 rtl/sincronizador.sv | 20 ++
 rtl/filtro_botao.sv | 99 +++++++++
 tb/tb_filtro_botao.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// filtro_pkg: shared FSM state type and default parameters for the button filter.
package filtro_pkg;
  typedef enum logic [1:0] {
    IDLE,
    CONFIRM_PRESS,
    PRESSED,
    CONFIRM_RELEASE
  } state_t;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int REPEAT_DELAY_DEF    = 1000;
  localparam int REPEAT_PERIOD_DEF   = 250;
endpackage

// File: rtl/sincronizador.sv
// sincronizador: two-flop synchronizer bringing an asynchronous level into the clk domain.
module sincronizador (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end
  assign o_q = r_q;
endmodule

// File: rtl/filtro_botao.sv
// filtro_botao: button debouncer with registered level and press strobe.
// Optional auto-repeat while held is enabled by defining FILTRO_AUTOREPEAT_EN.
module filtro_botao
  import filtro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic          w_sync;
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_level;
  logic          r_pulse;
  logic          w_press;
  logic          w_repeat;
  sincronizador u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (btn_in),
    .o_q (w_sync)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end
  // Confirm states count consecutive samples at the candidate level; any contrary sample aborts.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = '0;
    case (r_state)
      IDLE:            w_next = w_sync ? CONFIRM_PRESS : IDLE;
      CONFIRM_PRESS: begin
        w_next     = !w_sync ? IDLE : (r_cnt == CNT_LAST) ? PRESSED : CONFIRM_PRESS;
        w_cnt_next = (w_sync && r_cnt != CNT_LAST) ? r_cnt + 1'b1 : '0;
      end
      PRESSED:         w_next = w_sync ? PRESSED : CONFIRM_RELEASE;
      CONFIRM_RELEASE: begin
        w_next     = w_sync ? PRESSED : (r_cnt == CNT_LAST) ? IDLE : CONFIRM_RELEASE;
        w_cnt_next = (!w_sync && r_cnt != CNT_LAST) ? r_cnt + 1'b1 : '0;
      end
      default:         w_next = IDLE;
    endcase
  end
  assign w_press = (r_state == CONFIRM_PRESS) && (w_next == PRESSED);
`ifdef FILTRO_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] r_rep;
  logic          r_first;
  logic          w_rep_hit;
  assign w_rep_hit = (r_state == PRESSED) &&
                     (r_rep == (r_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1)));
  // Counts only in PRESSED; CONFIRM_RELEASE freezes it so a bounce back resumes the schedule.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rep   <= '0;
      r_first <= 1'b1;
    end else if (r_state == PRESSED) begin
      r_rep   <= w_rep_hit ? '0 : r_rep + 1'b1;
      r_first <= r_first && !w_rep_hit;
    end else if (r_state != CONFIRM_RELEASE) begin
      r_rep   <= '0;
      r_first <= 1'b1;
    end
  end
  assign w_repeat = w_rep_hit;
`else
  logic w_unused;
  assign w_unused = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign w_repeat = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_level <= (w_next == PRESSED) || (w_next == CONFIRM_RELEASE);
      r_pulse <= w_press || w_repeat;
    end
  end
  assign btn_level = r_level;
  assign btn_pulse = r_pulse;
endmodule

// File: tb/tb_filtro_botao.sv
// tb_filtro_botao: directed and random checks of filtro_botao against a run-length reference model.
// Honours FILTRO_AUTOREPEAT_EN for the expected repeat pulses.
module tb_filtro_botao;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef FILTRO_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_in = 1'b0;
  logic btn_level;
  logic btn_pulse;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses, pulse_cyc, rise_cyc, fall_cyc, c0;
  bit prev_level, lvl_seen;
  bit m_s1, m_s2, m_level, m_pulse;
  int m_run, m_held;

  filtro_botao #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_run = 0; m_held = 0;
  endtask

  // Level flips after D+1 consecutive synced samples disagreeing with it; synced = raw delayed two edges.
  task automatic model_edge();
    m_pulse = 0;
    if (m_level && m_run == 0) begin
      m_held++;
      if (AR && (m_held == RD || (m_held > RD && (m_held - RD) % RP == 0))) m_pulse = 1;
    end
    m_run = (m_s2 != m_level) ? m_run + 1 : 0;
    if (m_run == D + 1) begin
      m_level = !m_level;
      m_run = 0;
      m_held = 0;
      if (m_level) m_pulse = 1;
    end
    m_s2 = m_s1;
    m_s1 = btn_in;
  endtask

  task automatic step(input bit b);
    btn_in = b;
    @(posedge clk);
    model_edge();
    #1;
    chk("level", btn_level, m_level);
    chk("pulse", btn_pulse, m_pulse);
    if (btn_pulse) begin pulses++; pulse_cyc = cyc; end
    if (btn_level && !prev_level) rise_cyc = cyc;
    if (!btn_level && prev_level) fall_cyc = cyc;
    if (btn_level) lvl_seen = 1;
    prev_level = btn_level;
    @(negedge clk);
  endtask

  task automatic apply_reset(input bit b);
    btn_in = b;
    rst = 0;
    #1;
    chk("rst_level", btn_level, 0);
    chk("rst_pulse", btn_pulse, 0);
    model_reset();
    prev_level = 0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic clear_obs();
    pulses = 0; pulse_cyc = -1; rise_cyc = -1; fall_cyc = -1; lvl_seen = 0;
  endtask

  initial begin
    bit pat [5] = '{1, 0, 1, 1, 0};
    model_reset();
    prev_level = 0;
    @(negedge clk);
    #1;
    chk("init_level", btn_level, 0);
    chk("init_pulse", btn_pulse, 0);
    @(negedge clk);
    rst = 1;
    repeat (5) step(0);
    clear_obs();
    c0 = cyc + 1;
    repeat (10) step(1);
    chk("press_latency", rise_cyc - c0, 6);
    chk("press_pulse_at_rise", pulse_cyc, rise_cyc);
    repeat (12) step(0);
    chk("release_latency", fall_cyc - (c0 + 10), 6);
    chk("press_pulses", pulses, 1);
    clear_obs();
    foreach (pat[i]) step(pat[i]);
    c0 = cyc + 1;
    repeat (12) step(1);
    chk("bounce_latency", rise_cyc - c0, 6);
    chk("bounce_pulses", pulses, 1);
    repeat (12) step(0);
    clear_obs();
    repeat (3) step(1);
    repeat (10) step(0);
    chk("glitch_pulses", pulses, 0);
    chk("glitch_level", lvl_seen, 0);
    clear_obs();
    repeat (4) step(1);
    apply_reset(1);
    c0 = cyc + 1;
    repeat (10) step(1);
    chk("rst_mid_latency", rise_cyc - c0, 6);
    chk("rst_mid_pulses", pulses, 1);
    repeat (12) step(0);
    clear_obs();
    repeat (40) step(1);
    repeat (15) step(0);
    chk("hold40_pulses", pulses, AR ? 5 : 1);
    repeat (300) begin
      bit lvl = 1'($urandom_range(0, 1));
      int len = $urandom_range(1, 10);
      if ($urandom_range(0, 49) == 0) apply_reset(1'($urandom_range(0, 1)));
      repeat (len) step(lvl);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
